// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for a multicycle RV32I subset core (lw, sw, R-type, beq, addi,
// jal) built around one shared memory port and one shared ALU. Each cycle it
// steers the PC/IR enables, the memory request, the ALU operand muxes and the
// register-file write from the current state, the opcode and the ALU zero
// flag. Memory phases wait on mem_ready, retired instructions are counted and
// illegal opcodes are trapped.
//
// Parameters:
//   HALT_ON_ILLEGAL  1 = park in HALT on an illegal opcode, 0 = skip it
//   INSTRET_W        width of the retired-instruction counter
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   op               opcode field from IR
//   zero             ALU zero flag
//   mem_ready        memory access completes this cycle
//   mem_req          memory access requested
//   PCWrite          PC register enable
//   AdrSrc           memory address select: 0 = PC, 1 = ALUOut
//   MemWrite         memory write strobe
//   IRWrite          IR and OldPC enable
//   ResultSrc        result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
//   ALUSrcA          ALU A mux: 00 = PC, 01 = OldPC, 10 = rs1
//   ALUSrcB          ALU B mux: 00 = rs2, 01 = Imm, 10 = const 4
//   ALUOp            ALU decoder control: 00 = add, 01 = sub, 10 = funct
//   ImmSrc           immediate format
//   RegWrite         register-file write enable
//   illegal          sticky illegal-opcode flag
//   instret          retired-instruction count
//   state            current state, for debug
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter bit HALT_ON_ILLEGAL = 1'b1,
    parameter int INSTRET_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           op,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic [1:0]           ImmSrc,
    output logic                 RegWrite,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret,
    output logic [3:0]           state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t cur_state;
    state_t next_state;
    logic   set_illegal;
    logic   retire;

    assign state = cur_state;

    // State register. Reset is asynchronous so an in-flight instruction is
    // abandoned immediately and the core restarts from FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    // Sticky illegal flag and retired-instruction counter. Both are driven by
    // strobes from the next-state logic so they update on the same edge as
    // the transition that causes them; the counter wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal <= 1'b0;
            instret <= '0;
        end else begin
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (retire) begin
                instret <= instret + INSTRET_W'(1);
            end
        end
    end

    // Immediate format depends only on the opcode, independent of state.
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_LW, OP_ADDI: ImmSrc = 2'b00;
            OP_SW:          ImmSrc = 2'b01;
            OP_BEQ:         ImmSrc = 2'b10;
            OP_JAL:         ImmSrc = 2'b11;
            default:        ImmSrc = 2'b00;
        endcase
    end

    // Next-state and control decode. Everything is a Moore decode of the
    // state except the enables that qualify on mem_ready (so nothing fires
    // while a memory access is still pending) and the branch PC enable,
    // which qualifies on zero.
    always_comb begin
        next_state  = cur_state;
        mem_req     = 1'b0;
        PCWrite     = 1'b0;
        AdrSrc      = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        RegWrite    = 1'b0;
        set_illegal = 1'b0;
        retire      = 1'b0;

        case (cur_state)
            FETCH: begin
                // Instruction read at PC while the ALU computes PC+4.
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) begin
                    next_state = DECODE;
                end
            end
            DECODE: begin
                // OldPC + Imm lands in ALUOut as a speculative branch target.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = EXECUTER;
                    OP_ADDI:      next_state = EXECUTEI;
                    OP_BEQ:       next_state = BEQ;
                    OP_JAL:       next_state = JAL;
                    default: begin
                        set_illegal = 1'b1;
                        next_state  = HALT_ON_ILLEGAL ? HALT : FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) begin
                    next_state = MEMWB;
                end
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                // Write strobe only on the completing cycle: one pulse.
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = mem_ready;
                if (mem_ready) begin
                    retire     = 1'b1;
                    next_state = FETCH;
                end
            end
            EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b10;
                next_state = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUOp      = 2'b10;
                next_state = ALUWB;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            BEQ: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b01;
                PCWrite    = zero;
                retire     = 1'b1;
                next_state = FETCH;
            end
            JAL: begin
                // PC takes the target held in ALUOut; the ALU forms OldPC+4
                // for the link value written back in ALUWB.
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                PCWrite    = 1'b1;
                next_state = ALUWB;
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench for multicycle_controller. Two instances share every
// input: one parks on illegal opcodes (32-bit counter), the other skips them
// (4-bit counter, so wrap-around is exercised). A behavioural model expands
// each opcode into its list of phases and advances through that list,
// staying put on memory phases while mem_ready is low. Directed sequences
// with literal expectations come first, then a long randomized run.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    typedef struct packed {
        logic       mem_req;
        logic       PCWrite;
        logic       AdrSrc;
        logic       MemWrite;
        logic       IRWrite;
        logic [1:0] ResultSrc;
        logic [1:0] ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ALUOp;
        logic [1:0] ImmSrc;
        logic       RegWrite;
        logic [3:0] state;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;

    logic        h_mem_req, h_PCWrite, h_AdrSrc, h_MemWrite, h_IRWrite, h_RegWrite, h_illegal;
    logic [1:0]  h_ResultSrc, h_ALUSrcA, h_ALUSrcB, h_ALUOp, h_ImmSrc;
    logic [31:0] h_instret;
    logic [3:0]  h_state;

    logic        s_mem_req, s_PCWrite, s_AdrSrc, s_MemWrite, s_IRWrite, s_RegWrite, s_illegal;
    logic [1:0]  s_ResultSrc, s_ALUSrcA, s_ALUSrcB, s_ALUOp, s_ImmSrc;
    logic [3:0]  s_instret;
    logic [3:0]  s_state;

    ctl_t h_ctl, s_ctl;
    assign h_ctl = {h_mem_req, h_PCWrite, h_AdrSrc, h_MemWrite, h_IRWrite, h_ResultSrc,
                    h_ALUSrcA, h_ALUSrcB, h_ALUOp, h_ImmSrc, h_RegWrite, h_state};
    assign s_ctl = {s_mem_req, s_PCWrite, s_AdrSrc, s_MemWrite, s_IRWrite, s_ResultSrc,
                    s_ALUSrcA, s_ALUSrcB, s_ALUOp, s_ImmSrc, s_RegWrite, s_state};

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.HALT_ON_ILLEGAL(1'b1), .INSTRET_W(32)) dut_halt (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(h_mem_req), .PCWrite(h_PCWrite), .AdrSrc(h_AdrSrc), .MemWrite(h_MemWrite),
        .IRWrite(h_IRWrite), .ResultSrc(h_ResultSrc), .ALUSrcA(h_ALUSrcA), .ALUSrcB(h_ALUSrcB),
        .ALUOp(h_ALUOp), .ImmSrc(h_ImmSrc), .RegWrite(h_RegWrite), .illegal(h_illegal),
        .instret(h_instret), .state(h_state)
    );

    multicycle_controller #(.HALT_ON_ILLEGAL(1'b0), .INSTRET_W(4)) dut_skip (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(s_mem_req), .PCWrite(s_PCWrite), .AdrSrc(s_AdrSrc), .MemWrite(s_MemWrite),
        .IRWrite(s_IRWrite), .ResultSrc(s_ResultSrc), .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB),
        .ALUOp(s_ALUOp), .ImmSrc(s_ImmSrc), .RegWrite(s_RegWrite), .illegal(s_illegal),
        .instret(s_instret), .state(s_state)
    );

    // Behavioural model, index 0 = halting instance, 1 = skipping instance.
    // Each instruction is a list of phase numbers; the model walks it.
    int          m_seq     [2][6];
    int          m_len     [2];
    int          m_idx     [2];
    bit          m_bad     [2];
    bit          m_halted  [2];
    bit          m_illegal [2];
    int unsigned m_instret [2];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_seq[k]     = '{0, 0, 0, 0, 0, 0};
            m_len[k]     = 1;
            m_idx[k]     = 0;
            m_bad[k]     = 1'b0;
            m_halted[k]  = 1'b0;
            m_illegal[k] = 1'b0;
            m_instret[k] = 0;
        end
    endfunction

    function automatic void build_seq(input int k, input logic [6:0] o);
        m_bad[k] = 1'b0;
        case (o)
            OP_LW:   begin m_seq[k] = '{0, 1, 2, 3, 4, 0};  m_len[k] = 5; end
            OP_SW:   begin m_seq[k] = '{0, 1, 2, 5, 0, 0};  m_len[k] = 4; end
            OP_R:    begin m_seq[k] = '{0, 1, 6, 8, 0, 0};  m_len[k] = 4; end
            OP_ADDI: begin m_seq[k] = '{0, 1, 7, 8, 0, 0};  m_len[k] = 4; end
            OP_BEQ:  begin m_seq[k] = '{0, 1, 9, 0, 0, 0};  m_len[k] = 3; end
            OP_JAL:  begin m_seq[k] = '{0, 1, 10, 8, 0, 0}; m_len[k] = 4; end
            default: begin m_seq[k] = '{0, 1, 0, 0, 0, 0};  m_len[k] = 2; m_bad[k] = 1'b1; end
        endcase
    endfunction

    function automatic int model_state(input int k);
        return m_halted[k] ? 11 : m_seq[k][m_idx[k]];
    endfunction

    // Called on each rising edge with the inputs that were held over it.
    function automatic void model_advance();
        int st;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (!m_halted[k]) begin
                st = m_seq[k][m_idx[k]];
                if (!((st == 0 || st == 3 || st == 5) && !mem_ready)) begin
                    if (m_idx[k] == 0) build_seq(k, op);
                    if (m_idx[k] == m_len[k] - 1) begin
                        if (m_bad[k]) begin
                            m_illegal[k] = 1'b1;
                            if (k == 0) m_halted[k] = 1'b1;
                        end else begin
                            m_instret[k] = m_instret[k] + 1;
                        end
                        m_idx[k] = 0;
                    end else begin
                        m_idx[k] = m_idx[k] + 1;
                    end
                end
            end
        end
    endfunction

    // Control word each phase must present.
    function automatic ctl_t expect_ctl(input int st, input logic mr, input logic z, input logic [6:0] o);
        ctl_t e;
        e = '0;
        e.state = st[3:0];
        case (o)
            OP_SW:   e.ImmSrc = 2'b01;
            OP_BEQ:  e.ImmSrc = 2'b10;
            OP_JAL:  e.ImmSrc = 2'b11;
            default: e.ImmSrc = 2'b00;
        endcase
        case (st)
            0:  begin e.mem_req = 1; e.ALUSrcB = 2'b10; e.ResultSrc = 2'b10; e.IRWrite = mr; e.PCWrite = mr; end
            1:  begin e.ALUSrcA = 2'b01; e.ALUSrcB = 2'b01; end
            2:  begin e.ALUSrcA = 2'b10; e.ALUSrcB = 2'b01; end
            3:  begin e.mem_req = 1; e.AdrSrc = 1; end
            4:  begin e.ResultSrc = 2'b01; e.RegWrite = 1; end
            5:  begin e.mem_req = 1; e.AdrSrc = 1; e.MemWrite = mr; end
            6:  begin e.ALUSrcA = 2'b10; e.ALUOp = 2'b10; end
            7:  begin e.ALUSrcA = 2'b10; e.ALUSrcB = 2'b01; e.ALUOp = 2'b10; end
            8:  begin e.RegWrite = 1; end
            9:  begin e.ALUSrcA = 2'b10; e.ALUOp = 2'b01; e.PCWrite = z; end
            10: begin e.ALUSrcA = 2'b01; e.ALUSrcB = 2'b10; e.PCWrite = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Full comparison of both instances against the model.
    task automatic compare_model();
        ctl_t e;
        e = expect_ctl(model_state(0), mem_ready, zero, op);
        check_output("halt ctl", 32'(h_ctl), 32'(e));
        e = expect_ctl(model_state(1), mem_ready, zero, op);
        check_output("skip ctl", 32'(s_ctl), 32'(e));
        check_output("halt illegal", 32'(h_illegal), 32'(m_illegal[0]));
        check_output("skip illegal", 32'(s_illegal), 32'(m_illegal[1]));
        check_output("halt instret", h_instret, m_instret[0]);
        check_output("skip instret", 32'(s_instret), m_instret[1] % 16);
    endtask

    task automatic apply_stimulus(input logic [6:0] o, input logic mr, input logic z);
        op        = o;
        mem_ready = mr;
        zero      = z;
        #1;
    endtask

    // One cycle: compare on the falling edge, advance model on the rising edge.
    task automatic tick();
        @(negedge clk);
        compare_model();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    initial begin : main
        int         exp_st [7];
        logic       mr_pat [7];
        int         pulses;
        int         next_reset;
        logic [6:0] next_op;
        logic [6:0] legal [6];

        legal = '{OP_LW, OP_SW, OP_R, OP_ADDI, OP_BEQ, OP_JAL};

        rst_n = 1'b0;
        model_reset();
        apply_stimulus(OP_ADDI, 1'b1, 1'b0);
        #1;
        check_output("reset state", 32'(s_state), 0);
        check_output("reset instret", h_instret, 0);
        check_output("reset illegal", 32'(h_illegal), 0);
        @(posedge clk);
        model_advance();
        #1;
        rst_n = 1'b1;

        // addi, no stalls: phases 0,1,7,8 and a single write-back cycle
        exp_st[0:3] = '{0, 1, 7, 8};
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(OP_ADDI, 1'b1, 1'b0);
            check_output("addi state", 32'(s_state), 32'(exp_st[i]));
            check_output("addi RegWrite", 32'(s_RegWrite), 32'(i == 3));
            tick();
        end
        check_output("addi retired", 32'(s_instret), 1);

        // lw with two wait cycles in MEMREAD: seven cycles in all
        exp_st = '{0, 1, 2, 3, 3, 3, 4};
        mr_pat = '{1, 1, 1, 0, 0, 1, 1};
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(OP_LW, mr_pat[i], 1'b0);
            check_output("lw state", 32'(s_state), 32'(exp_st[i]));
            if (exp_st[i] == 3) check_output("lw AdrSrc", 32'(s_AdrSrc), 1);
            check_output("lw RegWrite", 32'(s_RegWrite), 32'(i == 6));
            tick();
        end
        check_output("lw done", 32'(s_state), 0);
        check_output("lw retired", 32'(s_instret), 2);

        // sw with one wait cycle: write strobe pulses exactly once
        exp_st[0:4] = '{0, 1, 2, 5, 5};
        mr_pat[0:4] = '{1, 1, 1, 0, 1};
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(OP_SW, mr_pat[i], 1'b0);
            check_output("sw state", 32'(s_state), 32'(exp_st[i]));
            pulses += int'(s_MemWrite);
            tick();
        end
        check_output("sw pulses", 32'(pulses), 1);
        check_output("sw retired", 32'(s_instret), 3);

        // beq taken then not taken, three cycles each
        for (int t = 1; t >= 0; t--) begin
            exp_st[0:2] = '{0, 1, 9};
            for (int i = 0; i < 3; i++) begin
                apply_stimulus(OP_BEQ, 1'b1, t[0]);
                check_output("beq state", 32'(s_state), 32'(exp_st[i]));
                if (i == 2) check_output("beq PCWrite", 32'(s_PCWrite), 32'(t));
                tick();
            end
        end
        check_output("beq retired", 32'(s_instret), 5);

        // jal: phases 0,1,10,8
        exp_st[0:3] = '{0, 1, 10, 8};
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(OP_JAL, 1'b1, 1'b0);
            check_output("jal state", 32'(s_state), 32'(exp_st[i]));
            if (i == 2) begin
                check_output("jal PCWrite", 32'(s_PCWrite), 1);
                check_output("jal ImmSrc", 32'(s_ImmSrc), 3);
            end
            if (i == 3) check_output("jal ResultSrc", 32'(s_ResultSrc), 0);
            tick();
        end
        check_output("jal retired", 32'(s_instret), 6);

        // illegal opcode: one instance parks, the other skips it
        apply_stimulus(OP_BAD, 1'b1, 1'b0);
        tick();
        apply_stimulus(OP_BAD, 1'b1, 1'b0);
        tick();
        check_output("halt parked", 32'(h_state), 11);
        check_output("halt illegal set", 32'(h_illegal), 1);
        check_output("skip back to fetch", 32'(s_state), 0);
        check_output("skip illegal set", 32'(s_illegal), 1);
        check_output("skip no retire", 32'(s_instret), 6);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(OP_BAD, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_output("halt held", 32'(h_state), 11);
            check_output("halt enables", 32'({h_mem_req, h_PCWrite, h_IRWrite, h_MemWrite, h_RegWrite}), 0);
            tick();
        end
        check_output("halt instret", h_instret, 6);

        // Asynchronous reset landing in EXECUTEI, with history to clear
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(OP_ADDI, 1'b1, 1'b0);
            tick();
        end
        check_output("pre-reset instret", 32'(s_instret), 1);
        apply_stimulus(OP_BAD, 1'b1, 1'b0);
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(OP_ADDI, 1'b1, 1'b0);
            tick();
        end
        check_output("in EXECUTEI", 32'(s_state), 7);
        rst_n = 1'b0;
        #1;
        check_output("async reset state", 32'(s_state), 0);
        check_output("async reset instret", 32'(s_instret), 0);
        check_output("async reset illegal", 32'(s_illegal), 0);
        check_output("async reset halt inst", 32'(h_state), 0);
        model_reset();
        tick();
        rst_n = 1'b1;

        // Randomized run with occasional asynchronous resets
        next_reset = $urandom_range(100, 300);
        next_op    = OP_ADDI;
        for (int c = 0; c < 4000; c++) begin
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if (c == next_reset) begin
                rst_n = 1'b0;
                model_reset();
                next_reset = next_reset + $urandom_range(100, 300);
            end
            if (m_idx[1] == 0) begin
                if ($urandom_range(0, 9) != 0) begin
                    next_op = legal[$urandom_range(0, 5)];
                end else begin
                    next_op = 7'($urandom_range(0, 127));
                    for (int j = 0; j < 6; j++) if (next_op == legal[j]) next_op = OP_BAD;
                end
            end
            apply_stimulus(next_op, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
